// File: rtl/rng_pkg.sv
// Shared types and constants for the rng_roll generator: FSM states,
// maximal-length Galois tap masks and the hex seven-segment glyph table.
package rng_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ROLL,
    SEARCH
  } state_t;

  // Active-low glyphs, bit order {g,f,e,d,c,b,a}, indexed by hex digit.
  localparam logic [6:0] SEG_HEX [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // Right-shift Galois tap masks giving a period of 2^width-1.
  function automatic logic [15:0] lfsr_taps(input int unsigned width);
    case (width)
      4:       return 16'h000C;
      5:       return 16'h0014;
      6:       return 16'h0030;
      7:       return 16'h0060;
      8:       return 16'h00B8;
      9:       return 16'h0110;
      10:      return 16'h0240;
      11:      return 16'h0500;
      12:      return 16'h0829;
      13:      return 16'h100D;
      14:      return 16'h2015;
      15:      return 16'h6000;
      16:      return 16'hD008;
      default: return 16'h0000;
    endcase
  endfunction

endpackage

// File: rtl/rng_lfsr.sv
// Free-running maximal-length Galois LFSR. Never reaches zero, so the
// candidate output (state - 1) spans 0..2^WIDTH-2.
module rng_lfsr
  import rng_pkg::*;
#(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned SEED  = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  output logic [WIDTH-1:0] lfsr_o,
  output logic [WIDTH-1:0] cand_o
);

  localparam logic [15:0]      TAPS16  = lfsr_taps(WIDTH);
  localparam logic [WIDTH-1:0] TAPS    = TAPS16[WIDTH-1:0];
  localparam logic [WIDTH-1:0] SEED_W  = WIDTH'(SEED);
  // An all-zero seed would lock the register, so it is replaced by 1.
  localparam logic [WIDTH-1:0] RST_VAL = (SEED_W == '0) ? WIDTH'(1) : SEED_W;

  logic [WIDTH-1:0] lfsr_q, lfsr_d;

  // Next state: shift right, fold taps back in when a one drops out.
  always_comb begin
    lfsr_d = lfsr_q >> 1;
    if (lfsr_q[0]) lfsr_d = lfsr_d ^ TAPS;
  end

  // State register, advances every clock.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) lfsr_q <= RST_VAL;
    else         lfsr_q <= lfsr_d;
  end

  assign lfsr_o = lfsr_q;
  assign cand_o = lfsr_q - WIDTH'(1);

endmodule

// File: rtl/rng_roll.sv
// Button-driven random number roller. Synchronises the roll button, waits
// for its release, then searches the LFSR stream for a value in
// [0, MAX_VAL] (no modulo bias) and shows it on active-low hex digits.
// Optional debounce filter compiled in with `define RNG_DEBOUNCE_EN.
module rng_roll
  import rng_pkg::*;
#(
  parameter int unsigned WIDTH     = 10,
  parameter int unsigned MAX_VAL   = 999,
  parameter int unsigned SEED      = 1,
  parameter int unsigned DIGITS    = 3,
  parameter int unsigned DB_CYCLES = 50000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  x,
  output logic [WIDTH-1:0]      random_num,
  output logic                  valid,
  output logic                  busy,
  output logic [7*DIGITS-1:0]   disp
);

  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);
  localparam int unsigned      PW    = 4 * DIGITS;

  logic [WIDTH-1:0] lfsr_state, cand;
  logic [1:0]       sync_q;
  logic             xs, xf, xf_dly_q, rise, fall, cand_ok, accept;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] random_num_q, random_num_d;
  logic             valid_q, valid_d;
  logic [PW-1:0]    num_ext;

  rng_lfsr #(
    .WIDTH (WIDTH),
    .SEED  (SEED)
  ) u_lfsr (
    .clk_i  (clk),
    .rst_ni (rst),
    .lfsr_o (lfsr_state),
    .cand_o (cand)
  );

  // Two-flop synchroniser for the asynchronous button.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_q <= '0;
    else      sync_q <= {sync_q[0], x};
  end

  assign xs = sync_q[1];

`ifdef RNG_DEBOUNCE_EN
  localparam int unsigned   CW      = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);

  logic [CW-1:0] db_cnt_q, db_cnt_d;
  logic          xf_q, xf_d;

  // Filtered level follows xs only after DB_CYCLES consecutive mismatches.
  always_comb begin
    xf_d     = xf_q;
    db_cnt_d = '0;
    if (xs != xf_q) begin
      if (db_cnt_q == DB_LAST) xf_d = xs;
      else                     db_cnt_d = db_cnt_q + 1'b1;
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      xf_q     <= 1'b0;
      db_cnt_q <= '0;
    end else begin
      xf_q     <= xf_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  assign xf = xf_q;
`else
  assign xf = xs;
`endif

  // Delayed copy of the filtered button for edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) xf_dly_q <= 1'b0;
    else      xf_dly_q <= xf;
  end

  assign rise = xf & ~xf_dly_q;
  assign fall = ~xf & xf_dly_q;

  // State 0 is unreachable; the guard keeps a wrapped cand from ever being taken.
  assign cand_ok = (lfsr_state != '0) && (cand <= MAX_W);

  // Next state and result capture.
  always_comb begin
    state_d      = state_q;
    accept       = 1'b0;
    unique case (state_q)
      IDLE:   if (rise) state_d = ROLL;
      ROLL:   if (fall) state_d = SEARCH;
      SEARCH: if (cand_ok) begin
        accept  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    random_num_d = accept ? cand : random_num_q;
    valid_d      = accept;
  end

  // FSM and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      random_num_q <= '0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      random_num_q <= random_num_d;
      valid_q      <= valid_d;
    end
  end

  assign random_num = random_num_q;
  assign valid      = valid_q;
  assign busy       = (state_q != IDLE);

  assign num_ext = PW'(random_num_q);

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    assign disp[7*i +: 7] = SEG_HEX[num_ext[4*i +: 4]];
  end

endmodule

// File: tb/tb_rng_roll.sv
// Self-checking bench for rng_roll: two WIDTH=4 instances (MAX_VAL=2 and
// MAX_VAL=14) driven by randomized press/hold/release timing, compared with
// a reference built from the published LFSR period and the roll timing rules.
module tb_rng_roll;

  localparam int MA = 2;
  localparam int MB = 14;
`ifdef RNG_DEBOUNCE_EN
  localparam int LATX = 8;
`else
  localparam int LATX = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        x_a = 1'b0;
  logic        x_b = 1'b0;
  logic [3:0]  rn_a, rn_b;
  logic        v_a, v_b, b_a, b_b;
  logic [6:0]  d_a;
  logic [13:0] d_b;

  int checks   = 0;
  int failures = 0;
  int idx      = 0;
  int last_a   = 0;
  int last_b   = 0;

  int         seq   [15] = '{1, 12, 6, 3, 13, 10, 5, 14, 7, 15, 11, 9, 8, 4, 2};
  logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  always #5 clk = ~clk;

  rng_roll #(.WIDTH(4), .MAX_VAL(MA), .SEED(1), .DIGITS(1), .DB_CYCLES(8)) dut_a (
    .clk(clk), .rst(rst), .x(x_a), .random_num(rn_a), .valid(v_a), .busy(b_a), .disp(d_a)
  );

  rng_roll #(.WIDTH(4), .MAX_VAL(MB), .SEED(0), .DIGITS(2), .DB_CYCLES(8)) dut_b (
    .clk(clk), .rst(rst), .x(x_b), .random_num(rn_b), .valid(v_b), .busy(b_b), .disp(d_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; the model LFSR index advances only while out of reset.
  task automatic tick();
    @(posedge clk);
    if (rst) idx++;
    #1;
  endtask

  task automatic do_roll(input int hold, input bit repress, input bit abort);
    int  cand_now;
    int  target;
    bit  da;
    bit  db;
    x_a = 1'b1;
    x_b = 1'b1;
    repeat (2 + LATX) tick();
    check("press_busy_a_pre", b_a, 0);
    check("press_busy_b_pre", b_b, 0);
    tick();
    check("press_busy_a", b_a, 1);
    check("press_busy_b", b_b, 1);
    for (int h = 0; h < hold; h++) begin
      tick();
      check("hold_busy_a", b_a, 1);
    end
    if (repress || abort) begin
      target = (1 - LATX + 30) % 15;
      for (int k = 0; k < 15 && (idx % 15) != target; k++) tick();
    end
    x_a = 1'b0;
    x_b = 1'b0;
    repeat (2 + LATX) tick();
    check("rel_busy_a", b_a, 1);
    check("rel_valid_a", v_a, 0);
    tick();
    check("search_busy_a", b_a, 1);
    check("search_valid_b", v_b, 0);
    if (abort) begin
      rst = 1'b0;
      #1;
      check("abort_valid_a", v_a, 0);
      check("abort_busy_a", b_a, 0);
      check("abort_busy_b", b_b, 0);
      check("abort_rn_a", rn_a, 0);
      check("abort_rn_b", rn_b, 0);
      check("abort_disp_a", d_a, glyph[0]);
      check("abort_lfsr_a", dut_a.u_lfsr.lfsr_q, 1);
      repeat (2) tick();
      check("abort_hold_valid_a", v_a, 0);
      check("abort_hold_valid_b", v_b, 0);
      idx    = 0;
      last_a = 0;
      last_b = 0;
      #2 rst = 1'b1;
      return;
    end
    da = 1'b0;
    db = 1'b0;
    for (int c = 0; c < 16 && !(da && db); c++) begin
      cand_now = seq[idx % 15] - 1;
      if (repress && c == 1) x_a = 1'b1;
      if (repress && c == 3) x_a = 1'b0;
      tick();
      if (!da) begin
        if (cand_now <= MA) begin
          check("acc_valid_a", v_a, 1);
          check("acc_rn_a", rn_a, cand_now);
          check("acc_busy_a", b_a, 0);
          check("acc_disp_a", d_a, glyph[cand_now]);
          last_a = cand_now;
          da     = 1'b1;
        end else begin
          check("rej_valid_a", v_a, 0);
          check("rej_busy_a", b_a, 1);
        end
      end else begin
        check("after_valid_a", v_a, 0);
      end
      if (!db) begin
        if (cand_now <= MB) begin
          check("acc_valid_b", v_b, 1);
          check("acc_rn_b", rn_b, cand_now);
          check("acc_disp_b", d_b, {glyph[0], glyph[cand_now]});
          check("latency_b", c, 0);
          last_b = cand_now;
          db     = 1'b1;
        end else begin
          check("rej_valid_b", v_b, 0);
        end
      end else begin
        check("after_valid_b", v_b, 0);
      end
    end
    x_a = 1'b0;
    tick();
    check("post_valid_a", v_a, 0);
    check("post_valid_b", v_b, 0);
    check("post_rn_a", rn_a, last_a);
    check("post_rn_b", rn_b, last_b);
    if (repress) begin
      for (int k = 0; k < 8; k++) begin
        tick();
        check("repress_busy_a", b_a, 0);
        check("repress_valid_a", v_a, 0);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check("rst_valid_a", v_a, 0);
    check("rst_busy_a", b_a, 0);
    check("rst_rn_a", rn_a, 0);
    check("rst_disp_a", d_a, 7'h40);
    check("rst_valid_b", v_b, 0);
    check("rst_busy_b", b_b, 0);
    check("rst_rn_b", rn_b, 0);
    check("rst_disp_b", d_b, 14'h2040);
    check("rst_lfsr_b_seed0", dut_b.u_lfsr.lfsr_q, 1);
    #5 rst = 1'b1;
    check("seq_start", dut_a.u_lfsr.lfsr_q, seq[0]);
    for (int n = 0; n < 16; n++) begin
      tick();
      check("seq_a", dut_a.u_lfsr.lfsr_q, seq[idx % 15]);
    end

`ifdef RNG_DEBOUNCE_EN
    x_a = 1'b1;
    x_b = 1'b1;
    repeat (5) tick();
    x_a = 1'b0;
    x_b = 1'b0;
    for (int n = 0; n < 20; n++) begin
      tick();
      check("bounce_busy_a", b_a, 0);
      check("bounce_busy_b", b_b, 0);
    end
`endif

    for (int r = 0; r < 20; r++) begin
      do_roll(int'($urandom_range(0, 6)), 1'b0, 1'b0);
      repeat ($urandom_range(0, 5)) begin
        tick();
        check("gap_busy_a", b_a, 0);
      end
    end

    do_roll(2, 1'b1, 1'b0);
    do_roll(1, 1'b0, 1'b0);
    do_roll(0, 1'b0, 1'b1);
    tick();
    check("post_abort_lfsr", dut_a.u_lfsr.lfsr_q, seq[idx % 15]);
    do_roll(3, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rng_roll.md
# rng_roll

Parametrised successor to the counter-capture random number generator. A free-running maximal-length Galois LFSR advances every clock. A roll button is synchronised and edge-detected, and on release the block searches forward for a value inside the configured range `[0, MAX_VAL]`, with no modulo bias. The result is registered, pulsed valid, and decoded onto `DIGITS` active-low hex seven-segment displays. It sits between the board button/switch inputs and the display bank.

## Interface
Parameters:
- `WIDTH`, default 10: LFSR and result width; legal 4..16.
- `MAX_VAL`, default 999: inclusive upper bound of the result; legal 0..2^WIDTH-2.
- `SEED`, default 1: LFSR reset state; a zero value is forced to 1.
- `DIGITS`, default 3: number of hex digits driven; must satisfy 4*DIGITS >= WIDTH.
- `DB_CYCLES`, default 50000: debounce stable-time in clocks. Used only with `RNG_DEBOUNCE_EN`.

Ports:
- `clk` in 1: single clock; all state on its rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `x` in 1: roll button, active-high while held, asynchronous to `clk`.
- `random_num` out WIDTH: last accepted result.
- `valid` out 1: one-cycle pulse when `random_num` updates.
- `busy` out 1: high in ROLL and SEARCH.
- `disp` out 7*DIGITS: digit i on bits [7i+6:7i]; segments {g,f,e,d,c,b,a}, active-low.

## Operation
- **LFSR:**
  - Galois right-shift update: `lsb = s[0]; s = s >> 1; if (lsb) s ^= TAPS[WIDTH]`.
  - Steps every cycle in every state and never reaches 0.
  - Candidate value: `cand = s - 1` (range 0..2^WIDTH-2).
- **Input path:**
  - `x` passes through a 2-flop synchroniser to produce `xs`.
  - `xs` is optionally debounced to produce `xf`.
  - `xf_d` is a 1-cycle delayed copy of `xf`.
  - `rise = xf & ~xf_d`; `fall = ~xf & xf_d`.
- **FSM:**
  - IDLE: on `rise`, go to ROLL.
  - ROLL: on `fall`, go to SEARCH.
  - SEARCH: each cycle, if `cand <= MAX_VAL`, load `random_num <= cand`, pulse `valid`, and go to IDLE. Otherwise stay in SEARCH.
  - `x` activity during SEARCH is ignored. A new `rise` is only honoured in IDLE.
- **Search bound:** a maximal-length sequence guarantees acceptance within 2^WIDTH-1-MAX_VAL SEARCH cycles.
- **Display:** digit i decodes `random_num[4i+3:4i]`, zero-extended above WIDTH. Hex glyphs 0-F.
- **Reset values (all outputs):**
  - LFSR = SEED (1 if SEED==0).
  - State = IDLE; synchroniser and debounce state = 0.
  - `random_num` = 0, `valid` = 0, `busy` = 0.
  - Every digit of `disp` shows "0" (7'b1000000).
- **Reset mid-operation:** asynchronous reset aborts ROLL/SEARCH immediately. No `valid` pulse is emitted.

## Timing
- Without debounce, a pin falling edge before clock edge e1 produces:
  - `xs` = 0 after e2;
  - SEARCH entered at e3;
  - earliest `valid` high after e4.
- Overall: 4 cycles minimum, plus one cycle per rejected candidate.
- `random_num` and `disp` change in the same cycle `valid` rises, and hold until the next acceptance.
- `valid` is never high on two consecutive cycles.
- `busy` rises the cycle after `rise` is seen and falls in the same cycle `valid` rises.

## Configuration
- Macro: `RNG_DEBOUNCE_EN`.
- **Defined:**
  - `xf` changes only after `xs` has differed from `xf` for `DB_CYCLES` consecutive cycles. The counter clears on any mismatch break.
  - Release-to-valid latency is 4+DB_CYCLES cycles minimum.
- **Undefined:** `xf = xs`; no counter is instantiated.

## Structure
- **Package `rng_pkg`:**
  - `state_t` enum (IDLE, ROLL, SEARCH).
  - `lfsr_taps(width)` function returning the maximal tap mask for widths 4..16 (e.g. 4 -> 4'b1100, 10 -> 10'b1001000000).
  - Seven-segment glyph constant array `SEG_HEX[16]`.
- **Sub-module `rng_lfsr`:** parametrised LFSR register with async reset to SEED. Outputs state and `cand`.
- **In the top level:** seven-segment decode is a generate loop over `DIGITS` using `SEG_HEX`.

## Test plan
- **Reset:** with WIDTH=4, SEED=1, assert `rst` low.
  - All outputs take their reset values.
  - After release, LFSR sequence is 1,12,6,3,13,10,5,14,7,15,11,9,8,4,2,1 (period 15).
- **Full-range accept:** with MAX_VAL=14, WIDTH=4, release `x`.
  - `valid` pulses exactly 4 cycles later.
  - `random_num` equals the model LFSR state at the check cycle, minus 1.
- **Narrow range:** with MAX_VAL=0, roll 20 times.
  - `random_num` = 0 every time.
  - Each SEARCH lasts ≤15 cycles, and `valid` occurs only in the cycle after the LFSR state is 1.
- **Re-press during SEARCH:** WIDTH=4, MAX_VAL=2.
  - The re-press is ignored.
  - Exactly one `valid` pulse, then a fresh press is required.
- **Reset mid-SEARCH:** assert `rst` while in SEARCH.
  - No `valid` pulse.
  - `random_num` = 0; LFSR = SEED.
- **Debounce (macro on, DB_CYCLES=8):** apply a 5-cycle bounce on `x`.
  - No ROLL entry.
  - A stable release yields `valid` at 12 cycles minimum.
